// File: rtl/uart_hex_dumper.sv
// uart_hex_dumper: byte stream to UART hex dump.
// Incoming bytes are stored in a FIFO. Each stored byte is sent as two lowercase
// ASCII hex digits followed by a space. A CR LF pair follows instead of the space
// after BYTES_PER_LINE bytes or after a byte marked last. The UART format is 8N1.
module uart_hex_dumper #(
  parameter int CLK_HZ         = 100000000,
  parameter int BAUD           = 115200,
  parameter int ADDR_W         = 6,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              clr_overflow,
  output logic              uart_tx,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   level
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_SP, S_CR, S_LF} state_t;

  // FIFO storage and pointers; pointers carry one extra wrap bit
  logic [8:0]      r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr, r_rd_ptr;
  logic            w_empty, w_full, w_push, w_drop;

  // Drain FSM
  state_t          r_state, w_next_state;
  logic [7:0]      r_byte;
  logic            r_last;
  logic [7:0]      r_line_cnt;
  logic            w_eol;
  logic            w_pop, w_ser_load;
  logic [7:0]      w_ser_data;

  // Serializer
  logic            r_ser_busy;
  logic            r_tx;
  logic [8:0]      r_shift;
  logic [3:0]      r_bit_idx;
  logic [CNT_W-1:0] r_clk_cnt;
  logic            w_ser_done;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  // Fullness is taken before this cycle's pop, so a write into a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign w_push  = in_valid & ~w_full;
  assign w_drop  = in_valid & w_full;
  assign level   = r_wr_ptr - r_rd_ptr;

  assign w_eol      = r_last | (r_line_cnt == 8'(BYTES_PER_LINE - 1));
  assign w_ser_done = r_ser_busy && (r_bit_idx == 4'd9) &&
                      (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  assign uart_tx = r_tx;
  assign busy    = ~w_empty | (r_state != S_IDLE) | r_ser_busy;

  // Write the FIFO payload
  // NOTE: the storage array has no reset. Only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {in_last, in_data};
  end

  // Advance the FIFO pointers on push and pop
  // NOTE: sequential state always uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sticky overflow flag. Setting it takes priority over clearing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow <= 1'b0;
    else if (w_drop)       overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic. Each character state advances on serializer done.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (!w_empty)  w_next_state = S_HI;
      S_HI:   if (w_ser_done) w_next_state = S_LO;
      S_LO:   if (w_ser_done) w_next_state = w_eol ? S_CR : S_SP;
      S_SP:   if (w_ser_done) w_next_state = S_IDLE;
      S_CR:   if (w_ser_done) w_next_state = S_LF;
      S_LF:   if (w_ser_done) w_next_state = S_IDLE;
      default:               w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: pop from IDLE, load the idle serializer with this state's character
  always_comb begin
    w_pop      = (r_state == S_IDLE) & ~w_empty;
    w_ser_load = (r_state != S_IDLE) & ~r_ser_busy;
    w_ser_data = 8'h20;
    case (r_state)
      S_HI:    w_ser_data = hex_char(r_byte[7:4]);
      S_LO:    w_ser_data = hex_char(r_byte[3:0]);
      S_CR:    w_ser_data = 8'h0D;
      S_LF:    w_ser_data = 8'h0A;
      default: w_ser_data = 8'h20;
    endcase
  end

  // Latch the popped entry and keep the per-line byte count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_line_cnt <= '0;
    end else begin
      if (w_pop) {r_last, r_byte} <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      if (r_state == S_LO && w_ser_done)
        r_line_cnt <= w_eol ? 8'd0 : r_line_cnt + 8'd1;
    end
  end

  // 8N1 serializer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT clocks each
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ser_busy <= 1'b0;
      r_tx       <= 1'b1;
      r_shift    <= '1;
      r_bit_idx  <= '0;
      r_clk_cnt  <= '0;
    end else if (!r_ser_busy) begin
      if (w_ser_load) begin
        r_ser_busy <= 1'b1;
        r_tx       <= 1'b0;
        r_shift    <= {1'b1, w_ser_data};
        r_bit_idx  <= '0;
        r_clk_cnt  <= '0;
      end
    end else if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
      r_clk_cnt <= '0;
      if (r_bit_idx == 4'd9) begin
        r_ser_busy <= 1'b0;
      end else begin
        r_tx      <= r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end
    end else begin
      r_clk_cnt <= r_clk_cnt + CNT_W'(1);
    end
  end

endmodule
